sram_rw_master: RTL
===================

# sram_rw_master

Request-side controller for the 1024x64 single-port SRAM macro wrapper (shared by local_mem and in_out_mem). It accepts read and write requests on a valid/ready channel and drives the SRAM port (cen/wen/bit_mask/addr/wdata). It absorbs the macro's fixed one-cycle read latency into a response FIFO, so read data is returned on a backpressurable valid/ready channel without ever losing a word.

## Interface
- AW, 10, address width (1024 words)
- DW, 64, data and bit-mask width
- RSP_DEPTH, 2, response FIFO depth; legal values are >= 2

- i_clk  in  1  clock; also drives the SRAM macro
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid && ready
- i_req_we  in  1  1 = write, 0 = read
- i_req_addr  in  AW  word address
- i_req_wdata  in  DW  write data
- i_req_mask  in  DW  per-bit write enable, 1 = bit written
- o_rsp_valid  out  1  read data valid
- i_rsp_ready  in  1  consumer ready
- o_rsp_rdata  out  DW  read data, in request order
- o_sram_cen  out  1  SRAM access enable, active high
- o_sram_wen  out  1  SRAM write enable, active high
- o_sram_bit_mask  out  DW  SRAM write mask, active high
- o_sram_addr  out  AW  SRAM address
- o_sram_wdata  out  DW  SRAM write data
- i_sram_rdata  in  DW  SRAM read data, valid the cycle after a read access
- o_busy  out  1  a read is in flight or the FIFO is non-empty

## Operation
- Signals:
  - acc = i_req_valid && o_req_ready.
  - pop = o_rsp_valid && i_rsp_ready.
  - cnt = FIFO occupancy.
  - infl = 1-bit register, set when a read was issued in the previous cycle.
- o_req_ready:
  - Writes: always 1, combinational.
  - Reads: 1 when (cnt + infl - pop) < RSP_DEPTH.
  - Forced to 0 while i_rst_n is low.
- SRAM drive, combinational from the request:
  - o_sram_cen = acc.
  - o_sram_wen = acc && i_req_we.
  - o_sram_bit_mask = i_req_mask when the access is a write, else 0.
  - o_sram_addr and o_sram_wdata follow the request inputs at all times.
- Read capture:
  - infl <= acc && !i_req_we.
  - When infl = 1, i_sram_rdata is pushed into the FIFO at the end of that cycle.
  - The push is guaranteed by the credit rule; a push into a full FIFO is an assertion failure.
- FIFO:
  - Circular, with read/write pointers that wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle are both performed, and cnt is unchanged.
  - o_rsp_valid = (cnt != 0). o_rsp_rdata = the head entry.
  - An entry is held stable while valid && !ready.
- Writes produce no response.
- Ordering is strict in-order. A write at cycle N followed by a read of the same address at N+1 returns the new data, because the macro orders them.
- o_busy = infl || (cnt != 0).

## Timing
- Reset values: o_rsp_valid 0, o_busy 0, o_sram_cen 0, o_sram_wen 0, o_sram_bit_mask 0, o_req_ready 0 while in reset. infl = 0, cnt = 0, pointers = 0.
- Write: accepted and issued to the SRAM in the same cycle N; no response.
- Read latency:
  - Accepted at cycle N.
  - Data on i_sram_rdata during N+1; pushed to the FIFO at the end of N+1.
  - o_rsp_valid high from N+2 (FIFO was empty and not stalled).
- Throughput: one read per cycle sustained with i_rsp_ready held at 1 and RSP_DEPTH = 2.
- Backpressure: with i_rsp_ready = 0, at most RSP_DEPTH reads are accepted in total (issued plus buffered). Further reads see o_req_ready = 0; writes are still accepted.
- Boundaries:
  - Full FIFO with a simultaneous pop: one new read may be accepted that cycle.
  - Empty FIFO with a simultaneous push: no pop occurs; o_rsp_valid rises next cycle.
- Reset asserted mid-operation: the in-flight read is discarded, the FIFO is flushed, and all outputs return to reset values immediately (asynchronously).

## Test plan
- Write addr 0x005 data 0xDEADBEEF_01234567 mask all-ones, then read 0x005 -> o_sram_cen and o_sram_wen high for one cycle with mask 0xFFFF_FFFF_FFFF_FFFF; read response 0xDEADBEEF_01234567 appears 2 cycles after read acceptance.
- Partial write to addr 0x3FF with mask 0x0000_0000_FFFF_FFFF and data 0x1111_1111_2222_2222 over a prior value of 0xAAAA_AAAA_BBBB_BBBB, then read 0x3FF -> returns 0xAAAA_AAAA_2222_2222.
- Eight back-to-back reads of addr 0..7 with i_rsp_ready = 1 -> o_req_ready stays 1 throughout; eight responses arrive in consecutive cycles, in address order.
- Reads streaming with i_rsp_ready = 0 -> exactly 2 reads accepted, then o_req_ready = 0 for reads while a write is still accepted; raising i_rsp_ready drains both entries in order with no loss or duplication.
- Random request/ready stimulus for 10k cycles against a reference memory model -> every response matches, FIFO never overflows, and responses stay in order.
- Assert i_rst_n low one cycle after a read is accepted -> o_rsp_valid 0 and o_busy 0 immediately; after release, no stale response appears.

Source files
------------

// File: rtl/sram_rw_master.sv
// Request-side controller for the 1024x64 single-port SRAM macro wrapper.
// Issues reads/writes from a valid/ready channel and returns read data through a credit-guarded FIFO.
module sram_rw_master #(
    parameter int AW        = 10,
    parameter int DW        = 64,
    parameter int RSP_DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    input  logic [DW-1:0] i_req_mask,

    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_rdata,

    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic [DW-1:0] o_sram_bit_mask,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_wdata,
    input  logic [DW-1:0] i_sram_rdata,

    output logic          o_busy
);

    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int CW1 = CW + 1;

    localparam logic [CW1-1:0] LP_DEPTH_EXT = CW1'(RSP_DEPTH);
    localparam logic [CW-1:0]  LP_FULL      = CW'(RSP_DEPTH);
    localparam logic [PW-1:0]  LP_LAST      = PW'(RSP_DEPTH - 1);

    logic [DW-1:0]  r_mem [RSP_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_cnt;
    logic           r_infl;

    logic           w_push;
    logic           w_pop;
    logic           w_rd_credit;
    logic           w_acc_core;
    logic           w_acc;
    logic           w_wr_acc;
    logic [CW1-1:0] w_outstanding;
    logic [PW-1:0]  w_wr_ptr_nxt;
    logic [PW-1:0]  w_rd_ptr_nxt;

    // A read may only be issued if its data is guaranteed a FIFO slot when it lands.
    assign w_push        = r_infl;
    assign w_pop         = o_rsp_valid && i_rsp_ready;
    assign w_outstanding = {1'b0, r_cnt} + CW1'(r_infl) - CW1'(w_pop);
    assign w_rd_credit   = (w_outstanding < LP_DEPTH_EXT);

    // Flop inputs use the ungated acceptance; reset already holds every flop, so only
    // the outputs need the explicit reset gating.
    assign w_acc_core = i_req_valid && (i_req_we || w_rd_credit);
    assign w_acc      = w_acc_core && i_rst_n;
    assign w_wr_acc   = w_acc && i_req_we;

    assign o_req_ready     = i_rst_n && (i_req_we || w_rd_credit);
    assign o_sram_cen      = w_acc;
    assign o_sram_wen      = w_wr_acc;
    assign o_sram_bit_mask = w_wr_acc ? i_req_mask : '0;
    assign o_sram_addr     = i_req_addr;
    assign o_sram_wdata    = i_req_wdata;

    assign o_rsp_valid = (r_cnt != '0);
    assign o_rsp_rdata = r_mem[r_rd_ptr];
    assign o_busy      = r_infl || (r_cnt != '0);

    assign w_wr_ptr_nxt = (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_infl   <= 1'b0;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_infl <= w_acc_core && !i_req_we;
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Data storage needs no reset: an entry is only visible once counted in r_cnt.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_sram_rdata;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && !w_pop && (r_cnt == LP_FULL)));
`endif

endmodule
